// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared VRAM arbiter state encoding, framebuffer and 640x480 timing.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DISP = 2'd1,
    S_WR0  = 2'd2,
    S_WR1  = 2'd3
  } arb_state_e;

  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

endpackage

`default_nettype wire

// File: rtl/vram_rr_arb.sv
// ============================================================================
// Module   : vram_rr_arb
// Purpose  : Two-way round-robin write grant with eligibility mask and enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vram_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       en,
  output logic [1:0] gnt
);

  logic       ptr_q;
  logic       ptr_d;
  logic [1:0] elig;

  always_comb begin
    elig = req & mask;
    gnt  = 2'b00;
    if (en) begin
      if (elig == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
      else               gnt = elig;
    end
    // Pointer favours the requester that did not just win.
    ptr_d = ptr_q;
    if (gnt[0])      ptr_d = 1'b1;
    else if (gnt[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares one single-port VRAM between the VGA fetch and two writers.
//            Option macro VRAM_ARB_VBLANK_LOCK_EN restricts writer 1 to vblank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vram_arbiter
  import vga_pkg::*;
#(
  parameter int FB_W   = vga_pkg::FB_W,
  parameter int FB_H   = vga_pkg::FB_H,
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int DATA_W = vga_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              visible,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_gnt,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rgb_out,
  output logic              rgb_valid,
  output logic              oob_err
);

  localparam logic [ADDR_W-1:0] FB_PIXELS = ADDR_W'(FB_W * FB_H);

  arb_state_e        state_q, state_d;
  logic [1:0]        wr_gnt_q, wr_gnt_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] rgb_out_q, rgb_out_d;
  logic              rgb_valid_q, rgb_valid_d;
  logic              oob_err_q, oob_err_d;
  logic              tick1_q, tick1_d;
  logic              tick2_q, tick2_d;
  logic              vis2_q, vis2_d;

  logic              fetch;
  logic              lock1_ok;
  logic [1:0]        arb_gnt;
  logic [ADDR_W-1:0] fetch_addr;
  logic              unused_lsbs;

  assign fetch       = p_tick & visible;
  assign fetch_addr  = ADDR_W'(pixel_y[9:1]) * ADDR_W'(FB_W) + ADDR_W'(pixel_x[9:1]);
  assign unused_lsbs = pixel_x[0] ^ pixel_y[0];

`ifdef VRAM_ARB_VBLANK_LOCK_EN
  assign lock1_ok = (pixel_y >= 10'(V_VISIBLE));
`else
  assign lock1_ok = 1'b1;
`endif

  // A requester being acknowledged this cycle still shows its old request.
  vram_rr_arb u_rr_arb (
    .clk   (clk),
    .reset (reset),
    .req   (wr_req),
    .mask  (~wr_gnt_q & {lock1_ok, 1'b1}),
    .en    (~fetch),
    .gnt   (arb_gnt)
  );

  always_comb begin
    state_d     = S_IDLE;
    wr_gnt_d    = 2'b00;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    oob_err_d   = oob_err_q;
    if (fetch) begin
      state_d    = S_DISP;
      ram_addr_d = fetch_addr;
    end else if (arb_gnt[0]) begin
      state_d     = S_WR0;
      wr_gnt_d    = 2'b01;
      ram_addr_d  = wr_addr0;
      ram_wdata_d = wr_data0;
      ram_we_d    = (wr_addr0 < FB_PIXELS);
      oob_err_d   = oob_err_q | (wr_addr0 >= FB_PIXELS);
    end else if (arb_gnt[1]) begin
      state_d     = S_WR1;
      wr_gnt_d    = 2'b10;
      ram_addr_d  = wr_addr1;
      ram_wdata_d = wr_data1;
      ram_we_d    = (wr_addr1 < FB_PIXELS);
      oob_err_d   = oob_err_q | (wr_addr1 >= FB_PIXELS);
    end

    // Display pipe: tick1 aligns with ram_addr, tick2 with ram_rdata.
    tick1_d     = p_tick;
    tick2_d     = tick1_q;
    vis2_d      = (state_q == S_DISP);
    rgb_valid_d = tick2_q;
    rgb_out_d   = rgb_out_q;
    if (tick2_q) rgb_out_d = vis2_q ? ram_rdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_gnt_q    <= 2'b00;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rgb_out_q   <= '0;
      rgb_valid_q <= 1'b0;
      oob_err_q   <= 1'b0;
      tick1_q     <= 1'b0;
      tick2_q     <= 1'b0;
      vis2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_gnt_q    <= wr_gnt_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rgb_out_q   <= rgb_out_d;
      rgb_valid_q <= rgb_valid_d;
      oob_err_q   <= oob_err_d;
      tick1_q     <= tick1_d;
      tick2_q     <= tick2_d;
      vis2_q      <= vis2_d;
    end
  end

  assign wr_gnt    = wr_gnt_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rgb_out   = rgb_out_q;
  assign rgb_valid = rgb_valid_q;
  assign oob_err   = oob_err_q;

endmodule

`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter FB_W, 320, framebuffer width in pixels (display is 2x-upscaled to 640).
REQ-002 Parameter FB_H, 240, framebuffer height in pixels.
REQ-003 Parameter ADDR_W, 17, RAM address width.
REQ-004 Parameter DATA_W, 12, RGB444 pixel width.
REQ-005 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 p_tick  in  1  pixel-rate strobe from VGA sync (1 of every 4 clk).
REQ-009 visible  in  1  active-video flag from VGA sync.
REQ-010 pixel_x, pixel_y  in  10 each  current display coordinate.
REQ-011 wr_req  in  2  write request per requester 0/1.
REQ-012 wr_addr0, wr_addr1  in  ADDR_W each  write address.
REQ-013 wr_data0, wr_data1  in  DATA_W each  write pixel.
REQ-014 wr_gnt  out  2  one-cycle write acknowledge per requester.
REQ-015 ram_we, ram_addr, ram_wdata  out  1/ADDR_W/DATA_W  single-port RAM command.
REQ-016 ram_rdata  in  DATA_W  RAM read data, valid 1 clk after ram_addr.
REQ-017 rgb_out  out  DATA_W  pixel to VGA DAC; rgb_valid  out  1  pixel strobe.
REQ-018 oob_err  out  1  sticky out-of-range write flag.

Function
REQ-019 Arbitration decision in cycle t SHALL drive registered ram_*, wr_gnt and state in cycle t+1.
REQ-020 State register SHALL be one of S_IDLE, S_DISP, S_WR0, S_WR1, naming the owner of the RAM access currently driven.
REQ-021 p_tick=1 with visible=1 SHALL win unconditionally -> S_DISP, ram_we=0, ram_addr=(pixel_y>>1)*FB_W+(pixel_x>>1).
REQ-022 p_tick=1 with visible=0 SHALL perform no fetch; slot goes to writers.
REQ-023 Otherwise an eligible wr_req SHALL be granted -> S_WR0/S_WR1, ram_we=1, addr/data from that requester, wr_gnt[i]=1 for exactly one cycle.
REQ-024 A requester whose wr_gnt is high in the current cycle SHALL be ineligible that cycle (no double grant); it presents next request or drops wr_req in the following cycle.
REQ-025 Requester SHALL hold wr_req/addr/data stable until wr_gnt; arbiter SHALL never grant a deasserted request.
REQ-026 Both eligible: round-robin pointer chooses; pointer moves to the other requester after each write grant.
REQ-027 No request and no fetch -> S_IDLE, ram_we=0, ram_addr held.
REQ-028 Write with addr >= FB_W*FB_H SHALL be acknowledged (wr_gnt) but ram_we=0, and oob_err set until reset.
REQ-029 Display pipeline: p_tick at t -> ram_addr t+1 -> ram_rdata t+2 -> rgb_out captured, rgb_valid=1 at t+3 (latency 3).
REQ-030 Non-visible p_tick at t SHALL give rgb_out=0, rgb_valid=1 at t+3; rgb_valid=0 on all non-p_tick-derived cycles, rgb_out held.
REQ-031 Sync signals (HS, VS, visible) SHALL be delayed 3 clk by the integrator to align with rgb_out.

Reset
REQ-032 Reset SHALL force state=S_IDLE, RR pointer=0, wr_gnt=0, ram_we=0, ram_addr=0, ram_wdata=0, rgb_out=0, rgb_valid=0, oob_err=0, pipeline valid bits=0.
REQ-033 Reset mid-grant SHALL drop the grant; requester re-requests, no write is lost silently (wr_gnt never seen).

Configuration
REQ-034 Macro VRAM_ARB_VBLANK_LOCK_EN defined: requester 1 eligible only while pixel_y >= 480 (vertical blank, tear-free updates); requester 0 unaffected.
REQ-035 Macro undefined: requester 1 eligible at all times per REQ-023..026.

Structure
REQ-036 Shared package vga_pkg SHALL hold the state enum, FB_W/FB_H/DATA_W constants and the 640x480 timing constants.
REQ-037 Sub-module vram_rr_arb (2-way round-robin grant with mask input) is natural; fetch address math stays in the top.

Verification
REQ-038 Reset mid-frame, release -> all outputs 0, first p_tick with visible, x=10,y=4 -> ram_addr=2*320+5=645 at t+1, rgb_valid at t+3.
REQ-039 wr_req=2'b11 held continuously, no p_tick -> wr_gnt alternates 01,10,01,10; ram_we each cycle.
REQ-040 wr_req[0] and p_tick+visible same cycle -> S_DISP first, wr_gnt[0] the next cycle, write not lost.
REQ-041 wr_addr0=76800 -> wr_gnt[0]=1, ram_we=0, oob_err=1 and stays 1.
REQ-042 VRAM_ARB_VBLANK_LOCK_EN, wr_req[1] at pixel_y=100 -> no grant until pixel_y=480, then granted.
REQ-043 ram_rdata=12'hABC for fetch at t -> rgb_out=12'hABC, rgb_valid=1 at t+3; non-visible p_tick -> rgb_out=0.
